// File: rtl/uram_table_arb.sv
// -----------------------------------------------------------------------------
// uram_table_arb
//
// Purpose:
//   Sequencer and arbiter for port A of a registered-output lookup table RAM.
//   After reset it zero-fills the whole table one line per cycle (optional).
//   It then shares the port between one line-wide config writer and two
//   DWIDTH-wide lookup requesters, one access per cycle. Each read is tagged
//   with its requester id and the memory output is steered back to that
//   requester exactly RD_LATENCY cycles after the grant. Port B of the memory
//   is not touched by this block.
//
// Ports:
//   clock        in   clock
//   rst          in   synchronous active-high reset
//   wr_valid     in   config write request
//   wr_addr      in   write word address (low SEL_BITS ignored by the memory)
//   wr_data      in   line to write
//   wr_ready     out  write granted this cycle
//   reqN_valid   in   lookup request, N = 0/1
//   reqN_addr    in   lookup word address
//   reqN_ready   out  lookup granted this cycle
//   respN_valid  out  lookup result valid (no backpressure)
//   respN_data   out  lookup result
//   init_done    out  high once the clear has finished, until next reset
//   mem_en       out  memory en_a
//   mem_wr_en    out  memory wr_en_a
//   mem_addr     out  memory address_a
//   mem_wr_data  out  memory wr_data_a
//   mem_q        in   memory q_a
// -----------------------------------------------------------------------------
module uram_table_arb #(
   parameter int DWIDTH       = 8,
   parameter int AWIDTH       = 12,
   parameter int LWIDTH       = 64,
   parameter int RD_LATENCY   = 3,
   parameter int CLEAR_EN     = 1,
   parameter int WR_BURST_MAX = 4
) (
   input  logic              clock,
   input  logic              rst,

   input  logic              wr_valid,
   input  logic [AWIDTH-1:0] wr_addr,
   input  logic [LWIDTH-1:0] wr_data,
   output logic              wr_ready,

   input  logic              req0_valid,
   input  logic [AWIDTH-1:0] req0_addr,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [AWIDTH-1:0] req1_addr,
   output logic              req1_ready,

   output logic              resp0_valid,
   output logic [DWIDTH-1:0] resp0_data,
   output logic              resp1_valid,
   output logic [DWIDTH-1:0] resp1_data,

   output logic              init_done,

   output logic              mem_en,
   output logic              mem_wr_en,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [LWIDTH-1:0] mem_wr_data,
   input  logic [DWIDTH-1:0] mem_q
);

   // Number of word-select bits inside one memory line.
   localparam int SEL_BITS = $clog2(LWIDTH / DWIDTH);
   // Width of the line index walked during the clear.
   localparam int LINE_W   = AWIDTH - SEL_BITS;
   // Burst counter must be able to hold WR_BURST_MAX itself.
   localparam int BURST_W  = $clog2(WR_BURST_MAX + 1);
   localparam logic [BURST_W-1:0] BURST_CAP = BURST_W'(WR_BURST_MAX);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t                r_state;
   logic [LINE_W-1:0]     r_line;
   logic [BURST_W-1:0]    r_burst;
   logic                  r_ptr;        // 0: req0 owns the next contended grant
   logic                  r_init_done;

   // Read tag pipeline: stage 0 is loaded at the grant, the last stage lines
   // up with the memory output.
   logic [RD_LATENCY-1:0] r_tag_vld;
   logic [RD_LATENCY-1:0] r_tag_id;
   logic [RD_LATENCY-1:0] w_tag_vld_next;
   logic [RD_LATENCY-1:0] w_tag_id_next;

   // ------------------------------------------------------------------------
   // Arbitration (combinational, same cycle as the valids)
   // ------------------------------------------------------------------------
   logic                  w_clr;
   logic                  w_run;
   logic                  w_any_rd;
   logic                  w_rd_both;
   logic                  w_rd_id;
   logic                  w_burst_block;
   logic                  w_wr_gnt;
   logic                  w_rd_gnt;
   logic [AWIDTH-1:0]     w_rd_addr;
   logic [AWIDTH-1:0]     w_clr_addr;
   logic                  w_resp_vld;

   // Reset forces every output low in the cycle it is asserted, including
   // the cycle before the state registers have been reloaded.
   assign w_clr         = (r_state == ST_CLEAR) && !rst;
   assign w_run         = (r_state == ST_RUN) && !rst;

   assign w_any_rd      = req0_valid | req1_valid;
   assign w_rd_both     = req0_valid & req1_valid;
   // Contended: pointer owner wins. Otherwise whoever is asking.
   assign w_rd_id       = w_rd_both ? r_ptr : req1_valid;
   assign w_rd_addr     = w_rd_id ? req1_addr : req0_addr;

   // A write yields only when it has used up its burst and a read is waiting.
   assign w_burst_block = (r_burst == BURST_CAP) && w_any_rd;
   assign w_wr_gnt      = w_run && wr_valid && !w_burst_block;
   assign w_rd_gnt      = w_run && w_any_rd && !w_wr_gnt;

   assign w_clr_addr    = AWIDTH'(r_line) << SEL_BITS;

   // ------------------------------------------------------------------------
   // Grant outputs
   // ------------------------------------------------------------------------
   assign wr_ready   = w_wr_gnt;
   assign req0_ready = w_rd_gnt && !w_rd_id;
   assign req1_ready = w_rd_gnt &&  w_rd_id;

   assign mem_en     = w_clr | w_wr_gnt | w_rd_gnt;
   assign mem_wr_en  = w_clr | w_wr_gnt;

   always_comb begin
      mem_addr = '0;
      if (w_clr) begin
         mem_addr = w_clr_addr;
      end else if (w_wr_gnt) begin
         mem_addr = wr_addr;
      end else if (w_rd_gnt) begin
         mem_addr = w_rd_addr;
      end
   end

   // Clear writes zeros; only a real write grant puts data on the bus.
   assign mem_wr_data = w_wr_gnt ? wr_data : '0;

   // ------------------------------------------------------------------------
   // Sequencer FSM: clear walk, burst counter, round-robin pointer
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (rst) begin
         r_state     <= (CLEAR_EN != 0) ? ST_CLEAR : ST_RUN;
         r_line      <= '0;
         r_burst     <= '0;
         r_ptr       <= 1'b0;
         r_init_done <= 1'b0;
      end else begin
         case (r_state)
            ST_CLEAR: begin
               // Line counter wraps back to 0 on the last line.
               r_line <= r_line + 1'b1;
               if (&r_line) begin
                  r_state     <= ST_RUN;
                  r_init_done <= 1'b1;
               end
            end
            ST_RUN: begin
               r_init_done <= 1'b1;
               if (w_wr_gnt) begin
                  r_burst <= (r_burst == BURST_CAP) ? BURST_CAP : r_burst + 1'b1;
               end else begin
                  r_burst <= '0;
               end
               // Only a contended grant hands ownership to the other side.
               if (w_rd_gnt && w_rd_both) begin
                  r_ptr <= ~r_ptr;
               end
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Tag pipeline
   // ------------------------------------------------------------------------
   assign w_tag_vld_next[0] = w_rd_gnt;
   assign w_tag_id_next[0]  = w_rd_id;

   genvar gi;
   generate
      for (gi = 1; gi < RD_LATENCY; gi++) begin : g_tag_shift
         assign w_tag_vld_next[gi] = r_tag_vld[gi-1];
         assign w_tag_id_next[gi]  = r_tag_id[gi-1];
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (rst) begin
         r_tag_vld <= '0;
         r_tag_id  <= '0;
      end else begin
         r_tag_vld <= w_tag_vld_next;
         r_tag_id  <= w_tag_id_next;
      end
   end

   // ------------------------------------------------------------------------
   // Response steering: exactly one requester sees a given memory word.
   // ------------------------------------------------------------------------
   assign w_resp_vld  = r_tag_vld[RD_LATENCY-1] && !rst;
   assign resp0_valid = w_resp_vld && !r_tag_id[RD_LATENCY-1];
   assign resp1_valid = w_resp_vld &&  r_tag_id[RD_LATENCY-1];
   assign resp0_data  = resp0_valid ? mem_q : '0;
   assign resp1_data  = resp1_valid ? mem_q : '0;

   assign init_done   = r_init_done && !rst;

endmodule

// File: tb/tb_uram_table_arb.sv
// -----------------------------------------------------------------------------
// tb_uram_table_arb
//
// Drives uram_table_arb against a small line-organised table model standing in
// for the RAM, and predicts every grant and response from a byte-addressed
// reference table plus the arbitration rules (burst limit, round-robin
// pointer, fixed read latency).
// -----------------------------------------------------------------------------
module tb_uram_table_arb;

   localparam int DWIDTH       = 8;
   localparam int AWIDTH       = 12;
   localparam int LWIDTH       = 64;
   localparam int RD_LATENCY   = 3;
   localparam int WR_BURST_MAX = 4;
   localparam int NLINES       = 512;
   localparam int NWORDS       = 4096;

   logic              clock;
   logic              rst;
   logic              wr_valid;
   logic [AWIDTH-1:0] wr_addr;
   logic [LWIDTH-1:0] wr_data;
   logic              wr_ready;
   logic              req0_valid;
   logic [AWIDTH-1:0] req0_addr;
   logic              req0_ready;
   logic              req1_valid;
   logic [AWIDTH-1:0] req1_addr;
   logic              req1_ready;
   logic              resp0_valid;
   logic [DWIDTH-1:0] resp0_data;
   logic              resp1_valid;
   logic [DWIDTH-1:0] resp1_data;
   logic              init_done;
   logic              mem_en;
   logic              mem_wr_en;
   logic [AWIDTH-1:0] mem_addr;
   logic [LWIDTH-1:0] mem_wr_data;
   logic [DWIDTH-1:0] mem_q;

   uram_table_arb #(
      .DWIDTH       (DWIDTH),
      .AWIDTH       (AWIDTH),
      .LWIDTH       (LWIDTH),
      .RD_LATENCY   (RD_LATENCY),
      .CLEAR_EN     (1),
      .WR_BURST_MAX (WR_BURST_MAX)
   ) dut (
      .clock       (clock),
      .rst         (rst),
      .wr_valid    (wr_valid),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_ready    (wr_ready),
      .req0_valid  (req0_valid),
      .req0_addr   (req0_addr),
      .req0_ready  (req0_ready),
      .req1_valid  (req1_valid),
      .req1_addr   (req1_addr),
      .req1_ready  (req1_ready),
      .resp0_valid (resp0_valid),
      .resp0_data  (resp0_data),
      .resp1_valid (resp1_valid),
      .resp1_data  (resp1_data),
      .init_done   (init_done),
      .mem_en      (mem_en),
      .mem_wr_en   (mem_wr_en),
      .mem_addr    (mem_addr),
      .mem_wr_data (mem_wr_data),
      .mem_q       (mem_q)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ------------------------------------------------------------------------
   // Stand-in for the RAM port A: line-wide writes, word reads, three
   // registered stages on the read path. Reset scrambles the contents so the
   // clear has something to erase.
   // ------------------------------------------------------------------------
   logic [LWIDTH-1:0] tb_lines [NLINES];
   logic [DWIDTH-1:0] rd_p0, rd_p1, rd_p2;

   always @(posedge clock) begin
      if (rst) begin
         for (int i = 0; i < NLINES; i++) tb_lines[i] <= {$urandom, $urandom};
      end else if (mem_en && mem_wr_en) begin
         tb_lines[mem_addr[11:3]] <= mem_wr_data;
      end
      rd_p0 <= tb_lines[mem_addr[11:3]][mem_addr[2:0]*8 +: 8];
      rd_p1 <= rd_p0;
      rd_p2 <= rd_p1;
   end
   assign mem_q = rd_p2;

   // ------------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------------
   typedef struct {
      int         due;
      bit         id;
      logic [7:0] data;
   } resp_t;

   logic [7:0] ref_mem [NWORDS];
   resp_t      rq[$];
   int         cyc;
   bit         ptr_m;
   int         burst_m;
   int         total;
   int         bad;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
      end
   endtask

   // One RUN-state cycle: drive, check against the rules, advance the model.
   task automatic step(input bit wv, input logic [11:0] wa, input logic [63:0] wd,
                       input bit v0, input logic [11:0] a0,
                       input bit v1, input logic [11:0] a1);
      bit         any_rd, wgnt, rgnt, rid, e0, e1;
      logic [11:0] ra;
      logic [7:0]  ed;
      resp_t       r;
      @(negedge clock);
      rst = 1'b0;
      wr_valid = wv; wr_addr = wa; wr_data = wd;
      req0_valid = v0; req0_addr = a0;
      req1_valid = v1; req1_addr = a1;
      #1;
      any_rd = v0 | v1;
      wgnt   = wv && !(burst_m == WR_BURST_MAX && any_rd);
      rgnt   = any_rd && !wgnt;
      rid    = (v0 && v1) ? ptr_m : v1;
      ra     = rid ? a1 : a0;

      check_val("wr_ready", wr_ready, wgnt);
      check_val("req0_ready", req0_ready, rgnt && !rid);
      check_val("req1_ready", req1_ready, rgnt && rid);
      check_val("mem_en", mem_en, wgnt | rgnt);
      if (wgnt | rgnt) begin
         check_val("mem_wr_en", mem_wr_en, wgnt);
         check_val("mem_addr", mem_addr, wgnt ? wa : ra);
      end
      if (wgnt) check_val("mem_wr_data", mem_wr_data, wd);
      check_val("init_done", init_done, 1'b1);

      e0 = 1'b0; e1 = 1'b0; ed = '0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
         r  = rq.pop_front();
         e0 = !r.id;
         e1 = r.id;
         ed = r.data;
      end
      check_val("resp0_valid", resp0_valid, e0);
      check_val("resp1_valid", resp1_valid, e1);
      if (e0) check_val("resp0_data", resp0_data, ed);
      if (e1) check_val("resp1_data", resp1_data, ed);

      if (wgnt) begin
         for (int k = 0; k < 8; k++) ref_mem[{wa[11:3], 3'(k)}] = wd[8*k +: 8];
         burst_m = (burst_m < WR_BURST_MAX) ? burst_m + 1 : WR_BURST_MAX;
         $display("cyc=%0d W  addr=0x%03h data=0x%016h", cyc, wa, wd);
      end else begin
         burst_m = 0;
      end
      if (rgnt) begin
         if (v0 && v1) ptr_m = !ptr_m;
         r.due  = cyc + RD_LATENCY;
         r.id   = rid;
         r.data = ref_mem[ra];
         rq.push_back(r);
         $display("cyc=%0d R%0d addr=0x%03h expect=0x%02h", cyc, rid, ra, r.data);
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, 0, '0);
   endtask

   task automatic rand_inputs();
      wr_valid   = 1'($urandom);
      wr_addr    = 12'($urandom);
      wr_data    = {$urandom, $urandom};
      req0_valid = 1'($urandom);
      req0_addr  = 12'($urandom);
      req1_valid = 1'($urandom);
      req1_addr  = 12'($urandom);
   endtask

   // Hold reset for n cycles with random request noise; everything stays low.
   task automatic reset_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         rst = 1'b1;
         rand_inputs();
         #1;
         check_val("rst_outputs",
                   {mem_en, mem_wr_en, wr_ready, req0_ready, req1_ready,
                    resp0_valid, resp1_valid, init_done}, 8'h00);
         cyc++;
      end
      rq.delete();
      burst_m = 0;
      ptr_m   = 1'b0;
      $display("cyc=%0d reset x%0d", cyc, n);
   endtask

   // Release reset and watch the full zero-fill, one line per cycle.
   task automatic clear_check();
      for (int i = 0; i < NLINES; i++) begin
         @(negedge clock);
         rst = 1'b0;
         rand_inputs();
         #1;
         check_val("clr_addr", mem_addr, 64'(i) << 3);
         check_val("clr_ctl",
                   {mem_en, mem_wr_en, wr_ready, req0_ready, req1_ready,
                    resp0_valid, resp1_valid, init_done, (mem_wr_data != '0)},
                   9'b110000000);
         cyc++;
      end
      for (int i = 0; i < NWORDS; i++) ref_mem[i] = 8'h00;
      $display("cyc=%0d clear of %0d lines observed", cyc, NLINES);
   endtask

   int bias_w, bias_r0, bias_r1;

   initial begin
      rst = 1'b1;
      wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
      req0_valid = 1'b0; req0_addr = '0;
      req1_valid = 1'b0; req1_addr = '0;
      cyc = 0; ptr_m = 1'b0; burst_m = 0; total = 0; bad = 0;

      reset_cycles(3);
      clear_check();

      // Freshly cleared table reads zero.
      step(0, '0, '0, 1, 12'h123, 0, '0);
      idle(4);

      // Write a line, read one byte of it the very next cycle.
      step(1, 12'h040, 64'h0807060504030201, 0, '0, 0, '0);
      step(0, '0, '0, 1, 12'h043, 0, '0);
      idle(4);

      // Both requesters contending for six cycles: strict alternation.
      for (int i = 0; i < 6; i++) step(0, '0, '0, 1, 12'($urandom), 1, 12'($urandom));
      idle(4);

      // Write stream against a waiting req1: burst limit lets req1 in.
      for (int i = 0; i < 10; i++)
         step(1, 12'($urandom), {$urandom, $urandom}, 0, '0, 1, 12'($urandom));
      idle(4);

      // Uncontended req1 grants must not move the pointer.
      for (int i = 0; i < 3; i++) step(0, '0, '0, 0, '0, 1, 12'($urandom));
      step(0, '0, '0, 1, 12'($urandom), 1, 12'($urandom));
      idle(4);

      // Random traffic with a different mix per segment.
      for (int s = 0; s < 20; s++) begin
         bias_w  = $urandom_range(10, 95);
         bias_r0 = $urandom_range(10, 95);
         bias_r1 = $urandom_range(10, 95);
         for (int i = 0; i < 80; i++) begin
            step(($urandom % 100) < bias_w,  12'($urandom), {$urandom, $urandom},
                 ($urandom % 100) < bias_r0, 12'($urandom),
                 ($urandom % 100) < bias_r1, 12'($urandom));
         end
      end
      idle(4);

      // Reset with two reads in flight: both responses are dropped and the
      // clear restarts from line 0.
      step(0, '0, '0, 1, 12'h010, 0, '0);
      step(0, '0, '0, 0, '0, 1, 12'h020);
      reset_cycles(1);
      clear_check();

      for (int i = 0; i < 60; i++) begin
         step(($urandom % 100) < 50, 12'($urandom), {$urandom, $urandom},
              ($urandom % 100) < 50, 12'($urandom),
              ($urandom % 100) < 50, 12'($urandom));
      end
      idle(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
